// File: rtl/vector_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : vector_output_serializer
// Description : Captures CPU vector words into a small FIFO and serializes
//               them one element per ready/valid transfer, with sticky
//               overflow reporting when the FIFO cannot accept a vector.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_output_serializer #(
    parameter int DATA_WIDTH      = 16,
    parameter int VECTOR_SIZE     = 6,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter int INDEX_WIDTH     = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorIn,
    input  logic                              vectorValid,
    output logic [DATA_WIDTH-1:0]             elementOut,
    output logic [INDEX_WIDTH-1:0]            elementIndex,
    output logic                              elementValid,
    input  logic                              elementReady,
    output logic                              lastElement,
    output logic [FIFO_ADDR_WIDTH:0]          fifoCount,
    output logic                              overflow,
    input  logic                              clearOverflow
);

    localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]           C_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]           C_CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_ADDR_WIDTH-1:0] C_PTR_ONE  = FIFO_ADDR_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0]     C_LAST_IDX = INDEX_WIDTH'(VECTOR_SIZE - 1);
    localparam logic [INDEX_WIDTH-1:0]     C_IDX_ONE  = INDEX_WIDTH'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [VEC_W-1:0]           mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q,  count_d;
    logic                       ovf_q,    ovf_d;
    logic [0:0]                 state_q,  state_d;
    logic [VEC_W-1:0]           hold_q,   hold_d;
    logic [INDEX_WIDTH-1:0]     idx_q,    idx_d;
    logic [DATA_WIDTH-1:0]      out_q,    out_d;
    logic                       valid_q,  valid_d;
    logic                       last_q,   last_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                  w_full;
    logic                  w_has_data;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_hs;
    logic                  w_at_last;
    logic                  w_load;
    logic [VEC_W-1:0]      w_head;
    logic [INDEX_WIDTH-1:0] w_idx_next;
    logic [DATA_WIDTH-1:0] w_hold_elem [VECTOR_SIZE];

    genvar k;
    generate
        for (k = 0; k < VECTOR_SIZE; k++) begin : g_elem
            assign w_hold_elem[k] = hold_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Fullness is judged on the registered count, so a same-cycle pop never makes room.
    assign w_full     = (count_q == C_FULL);
    assign w_has_data = (count_q != '0);
    assign w_push     = vectorValid & ~w_full;
    assign w_drop     = vectorValid & w_full;
    assign w_hs       = valid_q & elementReady;
    assign w_at_last  = (idx_q == C_LAST_IDX);
    assign w_head     = mem_q[rd_ptr_q];
    assign w_idx_next = idx_q + C_IDX_ONE;

    // A load pops the head either from idle or back-to-back after the last element.
    assign w_load = w_has_data &
                    ((state_q == ST_IDLE) | ((state_q == ST_SEND) & w_hs & w_at_last));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (w_load) begin
            state_d = ST_SEND;
            hold_d  = w_head;
            idx_d   = '0;
            out_d   = w_head[DATA_WIDTH-1:0];
            valid_d = 1'b1;
            last_d  = (C_LAST_IDX == '0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (!w_at_last) begin
                            idx_d  = w_idx_next;
                            out_d  = w_hold_elem[w_idx_next];
                            last_d = (w_idx_next == C_LAST_IDX);
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_load ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        case ({w_push, w_load})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (clearOverflow) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= vectorIn;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            idx_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign elementOut   = out_q;
    assign elementIndex = idx_q;
    assign elementValid = valid_q;
    assign lastElement  = last_q;
    assign fifoCount    = count_q;
    assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_output_serializer
// Description : Self-checking bench; a queue-based transaction model predicts
//               every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_output_serializer;

    localparam int DW    = 16;
    localparam int VS    = 6;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IW    = 3;
    localparam int VW    = VS * DW;

    logic          clock;
    logic          reset;
    logic [VW-1:0] vectorIn;
    logic          vectorValid;
    logic [DW-1:0] elementOut;
    logic [IW-1:0] elementIndex;
    logic          elementValid;
    logic          elementReady;
    logic          lastElement;
    logic [AW:0]   fifoCount;
    logic          overflow;
    logic          clearOverflow;

    vector_output_serializer #(
        .DATA_WIDTH      (DW),
        .VECTOR_SIZE     (VS),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_ADDR_WIDTH (AW),
        .INDEX_WIDTH     (IW)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .vectorIn      (vectorIn),
        .vectorValid   (vectorValid),
        .elementOut    (elementOut),
        .elementIndex  (elementIndex),
        .elementValid  (elementValid),
        .elementReady  (elementReady),
        .lastElement   (lastElement),
        .fifoCount     (fifoCount),
        .overflow      (overflow),
        .clearOverflow (clearOverflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: waiting vectors, the vector in service and its position.
    logic [VW-1:0] m_q [$];
    logic [VW-1:0] m_cur;
    int            m_idx;
    bit            m_busy;
    bit            m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input int base);
        logic [VW-1:0] v;
        for (int k = 0; k < VS; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VS; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_idx  = 0;
        m_busy = 0;
        m_ovf  = 0;
    endtask

    // Applies one clock edge to the model using the inputs held across that edge.
    task automatic model_edge();
        int pre;
        pre = m_q.size();
        if (!m_busy) begin
            if (pre > 0) begin
                m_cur  = m_q.pop_front();
                m_idx  = 0;
                m_busy = 1;
            end
        end else if (elementReady) begin
            if (m_idx < VS - 1) begin
                m_idx++;
            end else if (pre > 0) begin
                m_cur = m_q.pop_front();
                m_idx = 0;
            end else begin
                m_busy = 0;
            end
        end
        if (vectorValid && pre >= DEPTH) m_ovf = 1;
        else if (clearOverflow)          m_ovf = 0;
        if (vectorValid && pre < DEPTH) m_q.push_back(vectorIn);
    endtask

    task automatic compare_all();
        check_eq("elementValid", 32'(elementValid), 32'(m_busy));
        check_eq("fifoCount", 32'(fifoCount), 32'(m_q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (m_busy) begin
            check_eq("elementOut", 32'(elementOut), 32'(m_cur[m_idx*DW +: DW]));
            check_eq("elementIndex", 32'(elementIndex), 32'(m_idx));
            check_eq("lastElement", 32'(lastElement), 32'(m_idx == VS - 1));
        end else begin
            check_eq("lastElement_idle", 32'(lastElement), 32'd0);
        end
    endtask

    task automatic cycle(input logic vv, input logic [VW-1:0] vin, input logic rdy, input logic clr);
        vectorValid   = vv;
        vectorIn      = vin;
        elementReady  = rdy;
        clearOverflow = clr;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out"},   32'(elementOut),   32'd0);
        check_eq({tag, "_idx"},   32'(elementIndex), 32'd0);
        check_eq({tag, "_valid"}, 32'(elementValid), 32'd0);
        check_eq({tag, "_last"},  32'(lastElement),  32'd0);
        check_eq({tag, "_count"}, 32'(fifoCount),    32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),     32'd0);
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b0;
        vectorIn      = '0;
        vectorValid   = 1'b0;
        elementReady  = 1'b0;
        clearOverflow = 1'b0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Single vector, element k = k, ready held high.
        cycle(1'b1, mk_vec(0), 1'b1, 1'b0);
        idle_cycles(9, 1'b1);

        // Same vector with ready pattern 1,0,0 repeating.
        cycle(1'b1, mk_vec(0), 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0, '0, (i % 3) == 0, 1'b0);
        idle_cycles(3, 1'b1);

        // Two back-to-back vectors.
        cycle(1'b1, mk_vec(16'h1000), 1'b1, 1'b0);
        cycle(1'b1, mk_vec(16'h2000), 1'b1, 1'b0);
        idle_cycles(14, 1'b1);

        // Six vectors with the sink stalled: the sixth must be dropped.
        for (int v = 1; v <= 6; v++) cycle(1'b1, mk_vec(v * 16'h0100), 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        check_eq("ovf_after_burst", 32'(overflow), 32'd1);
        check_eq("count_full", 32'(fifoCount), 32'(DEPTH));
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, mk_vec(16'h0700), 1'b0, 1'b0);
        cycle(1'b1, mk_vec(16'h0800), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        idle_cycles(36, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);

        // Asynchronous reset while streaming index 3 with two vectors queued.
        cycle(1'b1, mk_vec(16'h3000), 1'b1, 1'b0);
        cycle(1'b1, mk_vec(16'h4000), 1'b1, 1'b0);
        cycle(1'b1, mk_vec(16'h5000), 1'b1, 1'b0);
        idle_cycles(2, 1'b1);
        check_eq("pre_reset_idx", 32'(elementIndex), 32'd3);
        check_eq("pre_reset_count", 32'(fifoCount), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #1;
        reset = 1'b1;
        idle_cycles(8, 1'b1);
        cycle(1'b1, mk_vec(16'h6000), 1'b1, 1'b0);
        idle_cycles(8, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 30), rnd_vec(),
                  ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 5));
        end
        idle_cycles(40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
